// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Pipeline sequencer for the 5-stage ARM core. Freezes the pipe
//            during pending SRAM accesses, flushes on taken branches, stalls
//            on data hazards, owns the NZCV register and keeps saturating
//            stall/flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
   parameter int FWD_EN      = 1,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,           // asynchronous, active-low
   input  logic             id_valid,
   input  logic [3:0]       id_src1,
   input  logic [3:0]       id_src2,
   input  logic             id_two_src,
   input  logic             exe_valid,
   input  logic [3:0]       exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_r_en,
   input  logic             exe_s,
   input  logic [3:0]       exe_status,
   input  logic             branch_taken,
   input  logic [3:0]       mem_dest,
   input  logic             mem_wb_en,
   input  logic             mem_req,
   input  logic             sram_ready,
   output logic             freeze_all,
   output logic             stall_if,
   output logic             bubble_id,
   output logic             flush_if,
   output logic [3:0]       sr_q,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int                C_WAIT_W  = $clog2(MEM_TIMEOUT + 1);
   localparam logic [C_WAIT_W-1:0] C_TIMEOUT = C_WAIT_W'(MEM_TIMEOUT);
   localparam logic              C_FWD     = (FWD_EN != 0);

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [C_WAIT_W-1:0]   r_wait_cnt;
   logic [C_WAIT_W-1:0]   w_wait_inc;
   logic                  w_match_exe;
   logic                  w_match_mem;
   logic                  w_raw;
   logic                  w_haz;

   // Source-operand matches against the EXE and MEM destinations
   assign w_match_exe = exe_valid & exe_wb_en &
                        ((exe_dest == id_src1) | (id_two_src & (exe_dest == id_src2)));
   assign w_match_mem = mem_wb_en &
                        ((mem_dest == id_src1) | (id_two_src & (mem_dest == id_src2)));

   // With forwarding only a load in EXE cannot be bypassed in time
   assign w_raw = C_FWD ? (w_match_exe & exe_mem_r_en) : (w_match_exe | w_match_mem);
   assign w_haz = id_valid & ~branch_taken & w_raw;

   // Wait counter saturates at the timeout so it can never wrap back to zero
   assign w_wait_inc = (r_wait_cnt == C_TIMEOUT) ? r_wait_cnt : r_wait_cnt + 1'b1;

   // Pipeline control outputs: freeze beats flush beats stall; all low in reset
   always_comb begin
      freeze_all = 1'b0;
      stall_if   = 1'b0;
      bubble_id  = 1'b0;
      flush_if   = 1'b0;
      if (rst) begin
         if (mem_req & ~sram_ready) begin
            freeze_all = 1'b1;
         end else if (branch_taken & exe_valid) begin
            flush_if  = 1'b1;
            bubble_id = 1'b1;
         end else if (w_haz) begin
            stall_if  = 1'b1;
            bubble_id = 1'b1;
         end
      end
   end

   // Next-state logic for the SRAM wait sequencer
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         RUN:      if (mem_req & ~sram_ready) w_state_next = MEM_WAIT;
         MEM_WAIT: if (sram_ready | ~mem_req) w_state_next = RUN;
         default:  w_state_next = RUN;
      endcase
   end

   // State register, wait counter and sticky timeout flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= RUN;
         r_wait_cnt <= '0;
         mem_err    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (r_state == RUN) begin
            if (w_state_next == MEM_WAIT) r_wait_cnt <= '0;
         end else begin
            r_wait_cnt <= w_wait_inc;
            // Flag only while the access is still outstanding
            if (mem_req & ~sram_ready & (w_wait_inc == C_TIMEOUT)) mem_err <= 1'b1;
         end
      end
   end

   // NZCV updates when the EXE instruction retires, even if it flushes younger ones
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_q <= 4'b0000;
      end else if (exe_valid & exe_s & ~freeze_all) begin
         sr_q <= exe_status;
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_if && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
         if (flush_if && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed bench for pipe_hazard_ctrl. Two instances share the
//            stimulus: A (forwarding, timeout 4, 4-bit counters) and
//            B (no forwarding, timeout 64, 16-bit counters). Expected values
//            are queued when inputs are driven and compared on the falling
//            edge, before the next rising edge updates state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_two_src, exe_valid, exe_wb_en, exe_mem_r_en, exe_s;
   logic       branch_taken, mem_wb_en, mem_req, sram_ready;
   logic [3:0] id_src1, id_src2, exe_dest, exe_status, mem_dest;

   logic        frz_a, stl_a, bub_a, fls_a, err_a;
   logic [3:0]  sr_a;
   logic [3:0]  scnt_a, fcnt_a;
   logic        frz_b, stl_b, bub_b, fls_b, err_b;
   logic [3:0]  sr_b;
   logic [15:0] scnt_b, fcnt_b;

   int total = 0;
   int bad   = 0;

   string       tag_q[$];
   int          sel_q[$];
   logic [15:0] exp_q[$];

   localparam int FRZ_A = 0, STL_A = 1, BUB_A = 2, FLS_A = 3, SR_A = 4, ERR_A = 5, SC_A = 6, FC_A = 7;
   localparam int FRZ_B = 8, STL_B = 9, BUB_B = 10, FLS_B = 11, SR_B = 12, ERR_B = 13, SC_B = 14, FC_B = 15;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.FWD_EN(1), .MEM_TIMEOUT(4), .CNT_W(4)) dut_a (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_two_src(id_two_src), .exe_valid(exe_valid), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
      .exe_mem_r_en(exe_mem_r_en), .exe_s(exe_s), .exe_status(exe_status),
      .branch_taken(branch_taken), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
      .mem_req(mem_req), .sram_ready(sram_ready), .freeze_all(frz_a), .stall_if(stl_a),
      .bubble_id(bub_a), .flush_if(fls_a), .sr_q(sr_a), .mem_err(err_a),
      .stall_cnt(scnt_a), .flush_cnt(fcnt_a));

   pipe_hazard_ctrl #(.FWD_EN(0), .MEM_TIMEOUT(64), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_two_src(id_two_src), .exe_valid(exe_valid), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
      .exe_mem_r_en(exe_mem_r_en), .exe_s(exe_s), .exe_status(exe_status),
      .branch_taken(branch_taken), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
      .mem_req(mem_req), .sram_ready(sram_ready), .freeze_all(frz_b), .stall_if(stl_b),
      .bubble_id(bub_b), .flush_if(fls_b), .sr_q(sr_b), .mem_err(err_b),
      .stall_cnt(scnt_b), .flush_cnt(fcnt_b));

   function automatic logic [15:0] obs(input int sel);
      case (sel)
         FRZ_A: return 16'(frz_a);
         STL_A: return 16'(stl_a);
         BUB_A: return 16'(bub_a);
         FLS_A: return 16'(fls_a);
         SR_A:  return 16'(sr_a);
         ERR_A: return 16'(err_a);
         SC_A:  return 16'(scnt_a);
         FC_A:  return 16'(fcnt_a);
         FRZ_B: return 16'(frz_b);
         STL_B: return 16'(stl_b);
         BUB_B: return 16'(bub_b);
         FLS_B: return 16'(fls_b);
         SR_B:  return 16'(sr_b);
         ERR_B: return 16'(err_b);
         SC_B:  return 16'(scnt_b);
         default: return fcnt_b;
      endcase
   endfunction

   // Queue an expectation for the next comparison point
   task automatic chk(input string tag, input int sel, input logic [15:0] v);
      tag_q.push_back(tag);
      sel_q.push_back(sel);
      exp_q.push_back(v);
   endtask

   // Pop every queued expectation and compare against the DUT now
   task automatic drain();
      string       t;
      int          s;
      logic [15:0] e;
      logic [15:0] o;
      while (exp_q.size() > 0) begin
         t = tag_q.pop_front();
         s = sel_q.pop_front();
         e = exp_q.pop_front();
         o = obs(s);
         total++;
         assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", t, o, e);
         end
      end
   endtask

   // Compare on the falling edge, then advance past the next rising edge
   task automatic step();
      @(negedge clk);
      drain();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      id_valid = 0; id_two_src = 0; exe_valid = 0; exe_wb_en = 0; exe_mem_r_en = 0;
      exe_s = 0; branch_taken = 0; mem_wb_en = 0; mem_req = 0; sram_ready = 0;
      id_src1 = 0; id_src2 = 0; exe_dest = 0; exe_status = 0; mem_dest = 0;
   endtask

   task automatic load_use();
      exe_valid = 1; exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 4'd3;
      id_valid = 1; id_src1 = 4'd3; id_src2 = 4'd7;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      clr_in();
      #22 rst = 1'b1;
      @(posedge clk);
      #1;

      // Reset values and a status load
      chk("rst_sr_a", SR_A, 0);   chk("rst_err_a", ERR_A, 0);
      chk("rst_scnt_a", SC_A, 0); chk("rst_fcnt_b", FC_B, 0);
      exe_valid = 1; exe_s = 1; exe_status = 4'h5;
      step();
      clr_in();
      chk("sr_load_a", SR_A, 5); chk("sr_load_b", SR_B, 5);

      // Enter a wait, then reset asynchronously in the middle of a cycle
      mem_req = 1; load_use();
      chk("pre_rst_frz_a", FRZ_A, 1); chk("pre_rst_frz_b", FRZ_B, 1);
      step();
      chk("pre_rst_frz2_a", FRZ_A, 1);
      step();
      #2 rst = 1'b0;
      #1;
      chk("in_rst_frz_a", FRZ_A, 0); chk("in_rst_frz_b", FRZ_B, 0);
      chk("in_rst_stl_a", STL_A, 0); chk("in_rst_bub_b", BUB_B, 0);
      chk("in_rst_sr_a", SR_A, 0);   chk("in_rst_err_a", ERR_A, 0);
      drain();
      clr_in();
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Load-use hazard: one stall cycle in both configurations
      load_use();
      chk("lu_stl_a", STL_A, 1); chk("lu_bub_a", BUB_A, 1); chk("lu_fls_a", FLS_A, 0);
      chk("lu_scnt0_a", SC_A, 0); chk("lu_stl_b", STL_B, 1); chk("post_rst_err_a", ERR_A, 0);
      chk("post_rst_frz_a", FRZ_A, 0);
      step();
      exe_valid = 0;
      chk("lu_done_stl_a", STL_A, 0); chk("lu_done_bub_a", BUB_A, 0);
      chk("lu_scnt1_a", SC_A, 1); chk("lu_scnt1_b", SC_B, 1);
      step();

      // Non-load producer: forwarding covers it, no-forwarding stalls
      exe_valid = 1; exe_mem_r_en = 0;
      chk("alu_stl_a", STL_A, 0); chk("alu_stl_b", STL_B, 1); chk("alu_bub_b", BUB_B, 1);
      step();

      // Second-source match, gated by id_two_src
      exe_mem_r_en = 1; exe_dest = 4'd7; id_src1 = 4'd1; id_two_src = 1;
      chk("src2_stl_a", STL_A, 1); chk("src2_scnt_b", SC_B, 2);
      step();
      id_two_src = 0;
      chk("src2_off_stl_a", STL_A, 0); chk("src2_off_stl_b", STL_B, 0);
      chk("src2_scnt_a", SC_A, 2);
      step();

      // MEM-stage match only matters without forwarding
      exe_valid = 0; mem_wb_en = 1; mem_dest = 4'd9; id_src1 = 4'd9;
      chk("mem_stl_a", STL_A, 0); chk("mem_stl_b", STL_B, 1); chk("mem_scnt_b", SC_B, 3);
      step();

      // Taken branch wins over a simultaneous hazard; status still retires
      clr_in(); load_use(); branch_taken = 1; exe_s = 1; exe_status = 4'h6;
      chk("br_fls_a", FLS_A, 1); chk("br_bub_a", BUB_A, 1); chk("br_stl_a", STL_A, 0);
      chk("br_fls_b", FLS_B, 1); chk("br_stl_b", STL_B, 0); chk("br_fcnt0_a", FC_A, 0);
      step();
      clr_in();
      chk("br_fcnt_a", FC_A, 1); chk("br_fcnt_b", FC_B, 1);
      chk("br_sr_a", SR_A, 6);   chk("br_sr_b", SR_B, 6);
      chk("br_scnt_a", SC_A, 2); chk("br_scnt_b", SC_B, 4);
      step();

      // Continuous hazard for 20 cycles: 4-bit counter pins at 15
      load_use();
      for (int i = 0; i < 20; i++) begin
         chk("sat_scnt_a", SC_A, (2 + i > 15) ? 16'd15 : 16'(2 + i));
         chk("sat_scnt_b", SC_B, 16'(4 + i));
         step();
      end
      clr_in();
      chk("sat_end_a", SC_A, 15); chk("sat_end_b", SC_B, 24);
      step();

      // Five-cycle SRAM wait with a branch and an S-bit instruction held in EXE
      load_use(); mem_req = 1; branch_taken = 1; exe_s = 1; exe_status = 4'b1010;
      for (int k = 0; k < 5; k++) begin
         chk("wt_frz_a", FRZ_A, 1); chk("wt_frz_b", FRZ_B, 1);
         chk("wt_fls_a", FLS_A, 0); chk("wt_stl_a", STL_A, 0);
         chk("wt_bub_a", BUB_A, 0); chk("wt_bub_b", BUB_B, 0);
         chk("wt_sr_a", SR_A, 6);   chk("wt_sr_b", SR_B, 6);
         chk("wt_err_a", ERR_A, 0); chk("wt_scnt_b", SC_B, 24);
         step();
      end
      // Timeout of 4 reached on the fifth frozen edge; ready now completes it
      sram_ready = 1;
      chk("rdy_frz_a", FRZ_A, 0); chk("rdy_fls_a", FLS_A, 1); chk("rdy_bub_a", BUB_A, 1);
      chk("rdy_stl_a", STL_A, 0); chk("rdy_sr_a", SR_A, 6);
      chk("to_err_a", ERR_A, 1);  chk("to_err_b", ERR_B, 0); chk("rdy_fcnt_a", FC_A, 1);
      step();
      clr_in();
      chk("done_sr_a", SR_A, 4'b1010); chk("done_sr_b", SR_B, 4'b1010);
      chk("done_fcnt_a", FC_A, 2);     chk("done_fcnt_b", FC_B, 2);
      chk("sticky_err_a", ERR_A, 1);
      step();

      // Single-cycle access produces no freeze
      mem_req = 1; sram_ready = 1;
      chk("fast_frz_a", FRZ_A, 0); chk("fast_frz_b", FRZ_B, 0);
      step();
      clr_in();
      chk("sticky2_err_a", ERR_A, 1); chk("idle_err_b", ERR_B, 0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage ARM core. Sits beside the IF/ID/EXE/MEM stage registers.
- Decides each cycle whether to:
  - freeze the whole pipe, while the MEM-stage SRAM access is pending;
  - flush on a taken branch resolved in EXE;
  - stall IF/ID and bubble EXE on a data hazard.
- Owns the architectural status register (NZCV) that feeds the condition check and the EXE carry-in.
- Keeps saturating stall/flush performance counters.

Parameters:
- FWD_EN, 1, 1 = forwarding unit present (stall only on load-use); 0 = stall on any RAW against EXE or MEM.
- MEM_TIMEOUT, 64, cycles in MEM_WAIT before the sticky mem_err is raised; range 1..65535.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_src1  in  4  Rn index in ID.
- id_src2  in  4  Rm/Rd index in ID.
- id_two_src  in  1  id_src2 is a real source.
- exe_valid  in  1  EXE holds a real instruction.
- exe_dest  in  4  EXE destination index.
- exe_wb_en  in  1  EXE writes back.
- exe_mem_r_en  in  1  EXE is a load.
- exe_s  in  1  EXE instruction has the S bit set.
- exe_status  in  4  NZCV produced by the ALU.
- branch_taken  in  1  taken branch in EXE.
- mem_dest  in  4  MEM destination index.
- mem_wb_en  in  1  MEM writes back.
- mem_req  in  1  MEM stage has a load or store.
- sram_ready  in  1  SRAM controller completion strobe.
- freeze_all  out  1  hold every pipeline register.
- stall_if  out  1  hold PC and the IF/ID register.
- bubble_id  out  1  load a NOP into ID/EXE (clear all control bits).
- flush_if  out  1  clear the IF/ID register.
- sr_q  out  4  architectural NZCV.
- mem_err  out  1  sticky SRAM timeout flag.
- stall_cnt  out  CNT_W  hazard-stall cycles.
- flush_cnt  out  CNT_W  branch flushes.

Behaviour:

Reset:
- Asynchronous on rst=0, independent of clk.
- Reset values: state=RUN, sr_q=0, mem_err=0, wait counter=0, stall_cnt=0, flush_cnt=0.
- Combinational outputs read 0 while in reset.
- Reset mid-MEM_WAIT aborts the wait with no error recorded.

FSM states:
- RUN: RUN→MEM_WAIT when mem_req=1 and sram_ready=0.
- MEM_WAIT: MEM_WAIT→RUN when sram_ready=1, or when mem_req=0 (protocol drop; no error).

Wait counter:
- Cleared on entry to MEM_WAIT.
- Increments each MEM_WAIT cycle and saturates.
- When it reaches MEM_TIMEOUT: mem_err←1 on that edge. mem_err is sticky until reset, and the state stays in MEM_WAIT.

freeze_all:
- Combinational: mem_req & ~sram_ready, in either state.
- A 1-cycle SRAM access (sram_ready already 1) gives zero freeze cycles.

Hazard term (haz):
- Condition id_valid & ~branch_taken must hold.
- FWD_EN=1: exe_valid & exe_mem_r_en & exe_wb_en & (exe_dest==id_src1 | (id_two_src & exe_dest==id_src2)).
- FWD_EN=0: the same match against EXE (with exe_valid & exe_wb_en, load or not), OR the same match against MEM with mem_wb_en.

Output priority (highest first):
1. freeze_all=1 forces stall_if=bubble_id=flush_if=0. Branch and hazard are ignored because the EXE/ID registers are held, so the events re-present after the freeze.
2. branch_taken & exe_valid gives flush_if=1 and bubble_id=1, with stall_if=0. The PC takes the branch target.
3. haz gives stall_if=1 and bubble_id=1.
4. Otherwise all outputs are 0.
- Outputs are combinational from inputs and state, with zero latency.

Status register:
- sr_q←exe_status on the edge when exe_valid & exe_s & ~freeze_all.
- This happens even if the same cycle flushes younger instructions, because the EXE instruction itself retires.
- sr_q is held otherwise.

Counters:
- stall_cnt +1 on each edge where stall_if=1.
- flush_cnt +1 on each edge where flush_if=1.
- Both saturate at all-ones and never wrap.

Test Plan:
- Reset: drive rst=0 asynchronously mid-cycle with mem_req=1, sram_ready=0 -> all outputs 0 immediately; after release state=RUN and counters=0.
- Load-use: FWD_EN=1, exe load dest=3, id_src1=3 -> stall_if=bubble_id=1 for exactly 1 cycle and stall_cnt=1. Repeat as a non-load (exe_mem_r_en=0) -> no stall. With FWD_EN=0 and a MEM dest match -> stall.
- Branch vs hazard: branch_taken=1 with a simultaneous ID hazard -> flush_if=bubble_id=1, stall_if=0, flush_cnt=1.
- SRAM wait: mem_req=1 with sram_ready low for 5 cycles -> freeze_all=1 for 5 cycles. A branch present in those cycles is suppressed, and exe_s=1 leaves sr_q unchanged. When ready rises, sr_q loads 4'b1010 and the state returns to RUN.
- Timeout: MEM_TIMEOUT=4, sram_ready held low for 10 cycles -> mem_err rises after the 4th wait cycle and stays 1 after ready.
- Saturation: CNT_W=4, continuous hazard for 20 cycles -> stall_cnt ends at 15.
